// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types for the systolic skew feeder: FSM states and the drain-length helper.
// Post-last-beat drain = deepest skew lane (ROWS-1 + COLS-1) plus PE MAC latency.
package systolic_skew_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

  function automatic int drain_cycles(input int rows, input int cols, input int pe_lat);
    return rows + cols - 2 + pe_lat;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_line.sv
// DEPTH-stage data+valid delay line; valid shifts every cycle, data only moves with a valid.
// Latency DEPTH cycles, no backpressure (never stalls).
module skew_line #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_vld,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_vld
);

  logic [DEPTH-1:0][DATA_W-1:0] r_dat;
  logic [DEPTH-1:0]             r_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dat <= '0;
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) r_dat[0] <= i_dat;
      // Bubbles leave the data register untouched; only the valid bit marks the gap.
      for (int s = 1; s < DEPTH; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) r_dat[s] <= r_dat[s-1];
      end
    end
  end

  assign o_dat = r_dat[DEPTH-1];
  assign o_vld = r_vld[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew feeder for the MAC array: lane r/c delayed r+1/c+1 cycles, tile_done after drain.
// in_ready low in DRAIN/DONE; optional perf counters under FEEDER_PERF_CNT_EN.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_MAX  = 256,
  parameter int PE_LAT = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ROWS-1:0][DATA_W-1:0]      in_act,
  input  logic [COLS-1:0][DATA_W-1:0]      in_wgt,
  input  logic                             in_last,
  output logic [ROWS-1:0][DATA_W-1:0]      act_data,
  output logic [ROWS-1:0]                  act_valid,
  output logic [COLS-1:0][DATA_W-1:0]      wgt_data,
  output logic [COLS-1:0]                  wgt_valid,
  output logic                             sync_out,
  output logic                             tile_done,
  output logic [$clog2(K_MAX+1)-1:0]       beat_count,
  output logic                             err_overrun
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_busy_cyc,
  output logic [31:0]                      perf_bubble_cyc
`endif
);

  localparam int CNT_W     = $clog2(K_MAX+1);
  localparam int DRAIN_CYC = drain_cycles(ROWS, COLS, PE_LAT);
  localparam int DR_W      = $clog2(DRAIN_CYC+2);

  feeder_state_e    r_state;
  logic [DR_W-1:0]  r_drain_cnt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_sync;
  logic             r_done;
  logic             r_err;
  logic             w_accept;
  logic             w_cap_hit;

  assign in_ready  = (r_state == IDLE) || (r_state == FEED);
  assign w_accept  = in_valid && in_ready;
  assign w_cap_hit = (r_beat_cnt == CNT_W'(K_MAX-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
      r_beat_cnt  <= '0;
      r_sync      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sync <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_beat_cnt  <= CNT_W'(1);
            r_sync      <= 1'b1;
            r_drain_cnt <= '0;
            if (in_last || (K_MAX == 1)) begin
              r_state <= DRAIN;
              r_err   <= !in_last;
            end else begin
              r_state <= FEED;
            end
          end
        end
        FEED: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            // Hitting K_MAX without in_last truncates the tile and flags the overrun.
            if (in_last || w_cap_hit) begin
              r_state <= DRAIN;
              r_err   <= !in_last;
            end
          end
        end
        DRAIN: begin
          if (r_drain_cnt == DR_W'(DRAIN_CYC-1)) r_state <= DONE;
          else                                   r_drain_cnt <= r_drain_cnt + 1'b1;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sync_out    = r_sync;
  assign tile_done   = r_done;
  assign err_overrun = r_err;
  assign beat_count  = r_beat_cnt;

  for (genvar r = 0; r < ROWS; r++) begin : g_act
    skew_line #(.DATA_W(DATA_W), .DEPTH(r+1)) u_line (
      .clk     (clk),
      .reset_n (reset_n),
      .i_dat   (in_act[r]),
      .i_vld   (w_accept),
      .o_dat   (act_data[r]),
      .o_vld   (act_valid[r])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wgt
    skew_line #(.DATA_W(DATA_W), .DEPTH(c+1)) u_line (
      .clk     (clk),
      .reset_n (reset_n),
      .i_dat   (in_wgt[c]),
      .i_vld   (w_accept),
      .o_dat   (wgt_data[c]),
      .o_vld   (wgt_valid[c])
    );
  end

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] r_busy_cyc;
  logic [31:0] r_bubble_cyc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_cyc   <= '0;
      r_bubble_cyc <= '0;
    end else begin
      if (r_state != IDLE)                r_busy_cyc   <= r_busy_cyc + 1'b1;
      if ((r_state == FEED) && !in_valid) r_bubble_cyc <= r_bubble_cyc + 1'b1;
    end
  end

  assign perf_busy_cyc   = r_busy_cyc;
  assign perf_bubble_cyc = r_bubble_cyc;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: table of tiles plus reset/corner sequences, scoreboarded lanes.
module tb_systolic_skew_feeder;

  localparam int DATA_W  = 8;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int K_MAX   = 4;
  localparam int PE_LAT  = 1;
  localparam int DRAIN_N = 7;
  localparam int CW      = 3;

  logic                        clk;
  logic                        reset_n;
  logic                        in_valid;
  logic                        in_ready;
  logic [ROWS-1:0][DATA_W-1:0] in_act;
  logic [COLS-1:0][DATA_W-1:0] in_wgt;
  logic                        in_last;
  logic [ROWS-1:0][DATA_W-1:0] act_data;
  logic [ROWS-1:0]             act_valid;
  logic [COLS-1:0][DATA_W-1:0] wgt_data;
  logic [COLS-1:0]             wgt_valid;
  logic                        sync_out;
  logic                        tile_done;
  logic [CW-1:0]               beat_count;
  logic                        err_overrun;
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]                 perf_busy_cyc;
  logic [31:0]                 perf_bubble_cyc;
`endif

  systolic_skew_feeder #(
    .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .PE_LAT(PE_LAT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_act      (in_act),
    .in_wgt      (in_wgt),
    .in_last     (in_last),
    .act_data    (act_data),
    .act_valid   (act_valid),
    .wgt_data    (wgt_data),
    .wgt_valid   (wgt_valid),
    .sync_out    (sync_out),
    .tile_done   (tile_done),
    .beat_count  (beat_count),
    .err_overrun (err_overrun)
`ifdef FEEDER_PERF_CNT_EN
    ,
    .perf_busy_cyc   (perf_busy_cyc),
    .perf_bubble_cyc (perf_bubble_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int             cyc;
    logic [DATA_W-1:0] dat;
  } ev_t;

  ev_t act_q[ROWS][$];
  ev_t wgt_q[COLS][$];
  ev_t mon_ev;

  int sync_exp    = -1;
  int done_exp    = -1;
  int err_exp     = -1;
  int done_pulses = 0;
  bit mon_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard: each accepted beat schedules one arrival per lane at cycle accept+1+lane.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      for (int r = 0; r < ROWS; r++) begin
        if (act_valid[r]) begin
          if (act_q[r].size() == 0) check($sformatf("act_extra[%0d]", r), 1, 0);
          else begin
            mon_ev = act_q[r].pop_front();
            check($sformatf("act_cyc[%0d]", r), cyc, mon_ev.cyc);
            check($sformatf("act_dat[%0d]", r), act_data[r], mon_ev.dat);
          end
        end else if (act_q[r].size() > 0 && act_q[r][0].cyc <= cyc) begin
          mon_ev = act_q[r].pop_front();
          check($sformatf("act_missing[%0d]", r), 0, 1);
        end
      end
      for (int c = 0; c < COLS; c++) begin
        if (wgt_valid[c]) begin
          if (wgt_q[c].size() == 0) check($sformatf("wgt_extra[%0d]", c), 1, 0);
          else begin
            mon_ev = wgt_q[c].pop_front();
            check($sformatf("wgt_cyc[%0d]", c), cyc, mon_ev.cyc);
            check($sformatf("wgt_dat[%0d]", c), wgt_data[c], mon_ev.dat);
          end
        end else if (wgt_q[c].size() > 0 && wgt_q[c][0].cyc <= cyc) begin
          mon_ev = wgt_q[c].pop_front();
          check($sformatf("wgt_missing[%0d]", c), 0, 1);
        end
      end
      if (tile_done) done_pulses++;
      if (sync_out || cyc == sync_exp)    check("sync_out", sync_out, cyc == sync_exp);
      if (tile_done || cyc == done_exp)   check("tile_done", tile_done, cyc == done_exp);
      if (err_overrun || cyc == err_exp)  check("err_overrun", err_overrun, cyc == err_exp);
    end
  end

  typedef struct {
    int nb;
    int bubble_after;
    bit last;
    int exp_cnt;
    bit exp_err;
    bit fixed_data;
  } vec_t;

  vec_t vecs[6];

  task automatic drive_beat(input logic [ROWS-1:0][DATA_W-1:0] a,
                            input logic [COLS-1:0][DATA_W-1:0] w,
                            input logic last, output int acc_cyc);
    ev_t e;
    int  g;
    @(negedge clk);
    in_valid = 1'b1;
    in_act   = a;
    in_wgt   = w;
    in_last  = last;
    g = 0;
    while (!in_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    acc_cyc = cyc;
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        e.cyc = cyc + 1 + r;
        e.dat = a[r];
        act_q[r].push_back(e);
      end
      for (int c = 0; c < COLS; c++) begin
        e.cyc = cyc + 1 + c;
        e.dat = w[c];
        wgt_q[c].push_back(e);
      end
    end
  endtask

  task automatic run_tile(input vec_t v, input int idx);
    logic [ROWS-1:0][DATA_W-1:0] a;
    logic [COLS-1:0][DATA_W-1:0] w;
    int acc, first, tl;
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] busy0, bub0;
    busy0 = perf_busy_cyc;
    bub0  = perf_bubble_cyc;
`endif
    first = 0;
    acc   = 0;
    for (int k = 0; k < v.nb; k++) begin
      for (int r = 0; r < ROWS; r++) a[r] = v.fixed_data ? DATA_W'(k+1) : DATA_W'($urandom);
      for (int c = 0; c < COLS; c++) w[c] = v.fixed_data ? DATA_W'(10*(k+1)) : DATA_W'($urandom);
      drive_beat(a, w, (k == v.nb-1) && v.last, acc);
      if (k == 0) begin
        first    = acc;
        sync_exp = acc + 1;
      end
      if (k == v.bubble_after) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    tl       = acc;
    err_exp  = v.exp_err ? tl + 1 : -1;
    done_exp = tl + 2 + DRAIN_N;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check($sformatf("ready_low_after_last t%0d", idx), in_ready, 0);
    while (cyc <= done_exp + 1) @(negedge clk);
    check($sformatf("beat_count t%0d", idx), beat_count, v.exp_cnt);
    check($sformatf("ready_idle t%0d", idx), in_ready, 1);
`ifdef FEEDER_PERF_CNT_EN
    check($sformatf("perf_bubble t%0d", idx), perf_bubble_cyc - bub0, (v.bubble_after >= 0) ? 1 : 0);
    check($sformatf("perf_busy t%0d", idx), perf_busy_cyc - busy0, tl - first + DRAIN_N + 1);
`endif
  endtask

  task automatic flush_sb();
    for (int r = 0; r < ROWS; r++) act_q[r].delete();
    for (int c = 0; c < COLS; c++) wgt_q[c].delete();
    sync_exp = -1;
    done_exp = -1;
    err_exp  = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROWS-1:0][DATA_W-1:0] a;
    logic [COLS-1:0][DATA_W-1:0] w;
    int acc, dp0;

    //          nb bub last cnt err fixed
    vecs[0] = '{3, -1, 1'b1, 3, 1'b0, 1'b1};
    vecs[1] = '{1, -1, 1'b1, 1, 1'b0, 1'b0};
    vecs[2] = '{2,  0, 1'b1, 2, 1'b0, 1'b0};
    vecs[3] = '{4, -1, 1'b0, 4, 1'b1, 1'b0};
    vecs[4] = '{4,  1, 1'b1, 4, 1'b0, 1'b0};
    vecs[5] = '{2, -1, 1'b1, 2, 1'b0, 1'b0};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_act   = '0;
    in_wgt   = '0;
    repeat (3) @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst act_valid", act_valid, 0);
    check("rst wgt_valid", wgt_valid, 0);
    check("rst act_data", act_data, 0);
    check("rst wgt_data", wgt_data, 0);
    check("rst beat_count", beat_count, 0);
    check("rst pulses", {sync_out, tile_done, err_overrun}, 0);
`ifdef FEEDER_PERF_CNT_EN
    check("rst perf", {perf_busy_cyc, perf_bubble_cyc}, 0);
`endif
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    run_tile(vecs[0], 0);

    // Reset while draining: lanes clear, no tile_done ever appears for the lost tile.
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < ROWS; r++) a[r] = DATA_W'($urandom);
      for (int c = 0; c < COLS; c++) w[c] = DATA_W'($urandom);
      drive_beat(a, w, k == 1, acc);
      if (k == 0) sync_exp = acc + 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dp0     = done_pulses;
    reset_n = 1'b0;
    flush_sb();
    #1;
    check("mid_rst act_valid", act_valid, 0);
    check("mid_rst wgt_valid", wgt_valid, 0);
    check("mid_rst in_ready", in_ready, 1);
    check("mid_rst beat_count", beat_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("mid_rst no tile_done", done_pulses - dp0, 0);

    for (int i = 1; i < 6; i++) run_tile(vecs[i], i);

    repeat (4) @(negedge clk);
    for (int r = 0; r < ROWS; r++) check($sformatf("act_q_empty[%0d]", r), act_q[r].size(), 0);
    for (int c = 0; c < COLS; c++) check($sformatf("wgt_q_empty[%0d]", c), wgt_q[c].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
